// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Top-level control for the 3-LED blinky boards.  It holds the board idle until
// the PLL has been locked for a settle period.  It then classifies the
// debounced push-button into short and long presses and drives the LEDs in one
// of three display modes:
//   STEP    - a short press increments a small counter shown on the LEDs
//   RUN     - a free-running binary counter, shown by its top bits; a short
//             press pauses or resumes it
//   PATTERN - a one-hot walking light; a short press reverses the direction
// A long press cycles STEP -> RUN -> PATTERN -> STEP.  If lock is lost in any
// of these modes, the block drops back to waiting for lock.
//
// Ports
//   clock       in   system clock (PLL output), rising-edge
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   PLL lock, asynchronous, synchronized internally
//   button      in   debounced button level, synchronous, 1 = pressed
//   leds        out  registered LED drive, LED_WIDTH bits
//   mode        out  registered: 0 not ready, 1 STEP, 2 RUN, 3 PATTERN
//   ready       out  registered, high in STEP / RUN / PATTERN
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int LED_WIDTH                 = 3,
    parameter int LONG_PRESS_CLOCK_PERIODS  = 16000000,
    parameter int LOCK_SETTLE_CLOCK_PERIODS = 1024,
    parameter int BLINK_PRESCALE_BITS       = 21
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 pll_locked,
    input  logic                 button,
    output logic [LED_WIDTH-1:0] leds,
    output logic [1:0]           mode,
    output logic                 ready
);

    localparam int HOLD_W   = (LONG_PRESS_CLOCK_PERIODS > 1) ? $clog2(LONG_PRESS_CLOCK_PERIODS) : 1;
    localparam int SETTLE_W = (LOCK_SETTLE_CLOCK_PERIODS > 1) ? $clog2(LOCK_SETTLE_CLOCK_PERIODS) : 1;
    localparam int RUN_W    = BLINK_PRESCALE_BITS + LED_WIDTH;

    localparam logic [HOLD_W-1:0]    HOLD_LAST   = HOLD_W'(LONG_PRESS_CLOCK_PERIODS - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(LOCK_SETTLE_CLOCK_PERIODS - 1);
    localparam logic [LED_WIDTH-1:0] WALK_INIT   = LED_WIDTH'(1);

    localparam logic [1:0] MODE_NONE    = 2'd0;
    localparam logic [1:0] MODE_STEP    = 2'd1;
    localparam logic [1:0] MODE_RUN     = 2'd2;
    localparam logic [1:0] MODE_PATTERN = 2'd3;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        STEP,
        RUN,
        PATTERN
    } state_t;

    state_t                   state;
    logic                     lock_meta;
    logic                     lock_s;
    logic                     button_q;
    logic [SETTLE_W-1:0]      settle_count;
    logic [HOLD_W-1:0]        hold_count;
    logic                     long_seen;
    logic [LED_WIDTH-1:0]     step_count;
    logic [RUN_W-1:0]         run_count;
    logic [BLINK_PRESCALE_BITS-1:0] prescaler;
    logic                     pause;
    logic                     dir_right;
    logic [LED_WIDTH-1:0]     walk;

    logic active;
    logic release_edge;
    logic long_fire;
    logic short_fire;
    logic tick;

    // Saturating increment: the hold counter parks on its last value so a
    // very long hold can never wrap around and look like a fresh press.
    function automatic logic [HOLD_W-1:0] hold_next(input logic [HOLD_W-1:0] count);
        if (count == HOLD_LAST) begin
            return count;
        end
        return count + 1'b1;
    endfunction

    // Rotation toward the MSB, the MSB wrapping into bit 0.
    function automatic logic [LED_WIDTH-1:0] rotate_left(input logic [LED_WIDTH-1:0] w);
        return (w << 1) | (w >> (LED_WIDTH - 1));
    endfunction

    // Rotation toward bit 0, bit 0 wrapping into the MSB.
    function automatic logic [LED_WIDTH-1:0] rotate_right(input logic [LED_WIDTH-1:0] w);
        return (w >> 1) | (w << (LED_WIDTH - 1));
    endfunction

    always_comb begin
        active       = (state == STEP) || (state == RUN) || (state == PATTERN);
        release_edge = button_q && !button;
        // long_seen both marks "already fired this hold" and masks a press
        // that was already down when the board became ready.
        long_fire    = active && button && (hold_count == HOLD_LAST) && !long_seen;
        short_fire   = active && release_edge && !long_seen;
        tick         = (prescaler == '1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
            button_q     <= 1'b0;
            state        <= WAIT_LOCK;
            settle_count <= '0;
            hold_count   <= '0;
            long_seen    <= 1'b0;
            step_count   <= '0;
            run_count    <= '0;
            prescaler    <= '0;
            pause        <= 1'b0;
            dir_right    <= 1'b0;
            walk         <= WALK_INIT;
            leds         <= '0;
            mode         <= MODE_NONE;
            ready        <= 1'b0;
        end else begin
            // Two-flop synchronizer for the asynchronous lock input.
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            button_q  <= button;

            case (state)
                WAIT_LOCK: begin
                    leds  <= '0;
                    mode  <= MODE_NONE;
                    ready <= 1'b0;
                    if (lock_s) begin
                        state        <= SETTLE;
                        settle_count <= '0;
                    end
                end

                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (settle_count == SETTLE_LAST) begin
                        state      <= STEP;
                        mode       <= MODE_STEP;
                        ready      <= 1'b1;
                        hold_count <= '0;
                        // A press already in progress is ignored until it
                        // is released.
                        long_seen  <= button;
                    end else begin
                        settle_count <= settle_count + 1'b1;
                    end
                end

                default: begin
                    if (!lock_s) begin
                        // Lock loss outranks any press or tick this cycle.
                        state      <= WAIT_LOCK;
                        leds       <= '0;
                        mode       <= MODE_NONE;
                        ready      <= 1'b0;
                        step_count <= '0;
                        run_count  <= '0;
                        prescaler  <= '0;
                        hold_count <= '0;
                        long_seen  <= 1'b0;
                        pause      <= 1'b0;
                        walk       <= WALK_INIT;
                        dir_right  <= 1'b0;
                    end else begin
                        hold_count <= button ? hold_next(hold_count) : '0;
                        if (release_edge) begin
                            long_seen <= 1'b0;
                        end else if (long_fire) begin
                            long_seen <= 1'b1;
                        end

                        // LEDs show the pre-edge value of the current mode,
                        // so they trail the internal state by one cycle.
                        case (state)
                            STEP:    leds <= step_count;
                            RUN:     leds <= run_count[RUN_W-1 -: LED_WIDTH];
                            default: leds <= walk;
                        endcase

                        if (long_fire) begin
                            // Mode change wins over a coincident prescaler
                            // tick; every entry restarts pause and the walker.
                            pause     <= 1'b0;
                            walk      <= WALK_INIT;
                            dir_right <= 1'b0;
                            case (state)
                                STEP: begin
                                    state     <= RUN;
                                    mode      <= MODE_RUN;
                                    run_count <= '0;
                                end
                                RUN: begin
                                    state     <= PATTERN;
                                    mode      <= MODE_PATTERN;
                                    prescaler <= '0;
                                end
                                default: begin
                                    // step_count deliberately survives the
                                    // round trip through the other modes.
                                    state <= STEP;
                                    mode  <= MODE_STEP;
                                end
                            endcase
                        end else begin
                            case (state)
                                STEP: begin
                                    if (short_fire) begin
                                        step_count <= step_count + 1'b1;
                                    end
                                end
                                RUN: begin
                                    if (!pause) begin
                                        run_count <= run_count + 1'b1;
                                    end
                                    if (short_fire) begin
                                        pause <= !pause;
                                    end
                                end
                                default: begin
                                    prescaler <= prescaler + 1'b1;
                                    // A tick in the same cycle as a reversal
                                    // still uses the old direction.
                                    if (tick) begin
                                        walk <= dir_right ? rotate_right(walk) : rotate_left(walk);
                                    end
                                    if (short_fire) begin
                                        dir_right <= !dir_right;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
